uart_program_loader: RTL and testbench



---
 rtl/uart_program_loader.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// UART program loader: 8N1 receiver feeding a count/word framer that writes 16-bit
// big-endian instructions into imem from address 0. Optional checksum byte: LOADER_CHECKSUM_EN.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int ADDR_W       = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              UART_TXD_IN,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              load_done,
    output logic              load_error,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        L_COUNT = 3'd0,
        L_HI    = 3'd1,
        L_LO    = 3'd2,
        L_CSUM  = 3'd3,
        L_DONE  = 3'd4,
        L_ERR   = 3'd5
    } ld_state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction
`else
    typedef enum logic [2:0] {
        L_COUNT = 3'd0,
        L_HI    = 3'd1,
        L_LO    = 3'd2,
        L_DONE  = 3'd4,
        L_ERR   = 3'd5
    } ld_state_t;
`endif

    logic              rx_meta_r;
    logic              rx_sync_r;
    rx_state_t         rx_state_r;
    logic [CNT_W-1:0]  rx_cnt_r;
    logic [2:0]        rx_bit_r;
    logic [7:0]        rx_shift_r;
    logic              rx_valid_r;
    logic              rx_ferr_r;

    ld_state_t         ld_state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        remain_r;
    logic [7:0]        hi_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_r;
`endif

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= UART_TXD_IN;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Byte receiver: mid-bit start check, 8 data samples LSB first, stop-bit check.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= '0;
                    if (!rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end else begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r <= '0;
                        rx_bit_r <= 3'd0;
                        // A line that is high again by mid-bit was only a glitch.
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_valid_r <= rx_sync_r;
                        rx_ferr_r  <= ~rx_sync_r;
                        rx_state_r <= RX_IDLE;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_cnt_r   <= '0;
                end
            endcase
        end
    end

    // Frame loader: count byte, then hi/lo pairs written to imem, then optional checksum.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_state_r <= L_COUNT;
            addr_r     <= '0;
            remain_r   <= 8'd0;
            hi_r       <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_r      <= 8'd0;
`endif
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 16'd0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            busy       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            busy    <= (ld_state_r != L_DONE) && (ld_state_r != L_ERR) &&
                       ((ld_state_r != L_COUNT) || (rx_state_r != RX_IDLE));
            case (ld_state_r)
                L_COUNT: begin
                    if (rx_ferr_r) begin
                        ld_state_r <= L_ERR;
                        load_error <= 1'b1;
                    end else if (rx_valid_r) begin
                        remain_r <= rx_shift_r;
`ifdef LOADER_CHECKSUM_EN
                        sum_r    <= rx_shift_r;
                        ld_state_r <= (rx_shift_r == 8'd0) ? L_CSUM : L_HI;
`else
                        if (rx_shift_r == 8'd0) begin
                            ld_state_r <= L_DONE;
                            load_done  <= 1'b1;
                        end else begin
                            ld_state_r <= L_HI;
                        end
`endif
                    end else begin
                        ld_state_r <= L_COUNT;
                    end
                end
                L_HI: begin
                    if (rx_ferr_r) begin
                        ld_state_r <= L_ERR;
                        load_error <= 1'b1;
                    end else if (rx_valid_r) begin
                        hi_r       <= rx_shift_r;
`ifdef LOADER_CHECKSUM_EN
                        sum_r      <= csum_add(sum_r, rx_shift_r);
`endif
                        ld_state_r <= L_LO;
                    end else begin
                        ld_state_r <= L_HI;
                    end
                end
                L_LO: begin
                    if (rx_ferr_r) begin
                        ld_state_r <= L_ERR;
                        load_error <= 1'b1;
                    end else if (rx_valid_r) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= addr_r;
                        imem_wdata <= {hi_r, rx_shift_r};
                        addr_r     <= addr_r + ADDR_W'(1);
                        remain_r   <= remain_r - 8'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_r      <= csum_add(sum_r, rx_shift_r);
                        ld_state_r <= (remain_r == 8'd1) ? L_CSUM : L_HI;
`else
                        // load_done follows from L_DONE, one cycle behind the final write.
                        ld_state_r <= (remain_r == 8'd1) ? L_DONE : L_HI;
`endif
                    end else begin
                        ld_state_r <= L_LO;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                L_CSUM: begin
                    if (rx_ferr_r) begin
                        ld_state_r <= L_ERR;
                        load_error <= 1'b1;
                    end else if (rx_valid_r) begin
                        if (csum_add(sum_r, rx_shift_r) == 8'd0) begin
                            ld_state_r <= L_DONE;
                            load_done  <= 1'b1;
                        end else begin
                            ld_state_r <= L_ERR;
                            load_error <= 1'b1;
                        end
                    end else begin
                        ld_state_r <= L_CSUM;
                    end
                end
`endif
                L_DONE: begin
                    load_done <= 1'b1;
                end
                L_ERR: begin
                    load_error <= 1'b1;
                end
                default: begin
                    ld_state_r <= L_ERR;
                    load_error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: directed frames against a byte-level frame model.
module tb_uart_program_loader;

    localparam int CPB = 16;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef logic [7:0]  bytes_t[$];
    typedef logic [23:0] wr_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        UART_TXD_IN = 1'b1;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        load_done;
    logic        load_error;
    logic        busy;

    int  checks = 0;
    int  failures = 0;
    wr_t exp_q[$];
    wr_t log_q[$];
    bit  exp_done, exp_err, exp_done_after_we;
    bit  we_prev, done_prev, err_prev;
    bytes_t tmp;

    always #5 CLK = ~CLK;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8)) dut (
        .CLK(CLK), .RST(RST), .UART_TXD_IN(UART_TXD_IN),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .load_done(load_done), .load_error(load_error), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Frame model: which words get written, and whether the frame ends done or in error.
    task automatic build_model(input bytes_t fr, input int ferr_idx);
        int n;
        logic [7:0] sum;
        logic [7:0] hi;
        bit term;
        exp_q.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_done_after_we = 1'b0;
        n = 0; sum = 8'd0; hi = 8'd0; term = 1'b0;
        foreach (fr[i]) begin
            if (term) continue;
            if (i == ferr_idx) begin
                exp_err = 1'b1; term = 1'b1;
            end else if (i == 0) begin
                n = int'(fr[0]); sum = fr[0];
                if (n == 0 && !CSUM) begin exp_done = 1'b1; term = 1'b1; end
            end else if (i <= 2 * n) begin
                sum = sum + fr[i];
                if (i % 2 == 1) hi = fr[i];
                else exp_q.push_back({8'(i / 2 - 1), hi, fr[i]});
                if (i == 2 * n && !CSUM) begin
                    exp_done = 1'b1; exp_done_after_we = 1'b1; term = 1'b1;
                end
            end else if (CSUM) begin
                if (8'(sum + fr[i]) == 8'd0) exp_done = 1'b1;
                else exp_err = 1'b1;
                term = 1'b1;
            end
        end
    endtask

    function automatic bytes_t with_csum(input bytes_t fr);
        bytes_t r;
        logic [7:0] s;
        r = fr; s = 8'd0;
        if (CSUM) begin
            foreach (fr[i]) s = s + fr[i];
            r.push_back(8'(8'd0 - s));
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        UART_TXD_IN = 1'b0;
        repeat (CPB) tick();
        for (int k = 0; k < 8; k++) begin
            UART_TXD_IN = b[k];
            repeat (CPB) tick();
        end
        UART_TXD_IN = good_stop;
        repeat (CPB) tick();
        UART_TXD_IN = 1'b1;
        if (!good_stop) repeat (2 * CPB) tick();
    endtask

    task automatic send_frame(input bytes_t fr, input int ferr_idx);
        build_model(fr, ferr_idx);
        foreach (fr[i]) send_byte(fr[i], i != ferr_idx);
        repeat (4) tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        exp_q.delete(); log_q.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_done_after_we = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},    {31'd0, imem_we},    32'd0);
        chk({tag, "_addr"},  {24'd0, imem_addr},  32'd0);
        chk({tag, "_wdata"}, {16'd0, imem_wdata}, 32'd0);
        chk({tag, "_done"},  {31'd0, load_done},  32'd0);
        chk({tag, "_error"}, {31'd0, load_error}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy},       32'd0);
    endtask

    // Cycle-by-cycle comparison of the write port and status edges against the model.
    always @(negedge CLK) begin
        if (imem_we) begin
            chk("we_one_cycle", {31'd0, we_prev}, 32'd0);
            log_q.push_back({imem_addr, imem_wdata});
            chk("write_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                chk("write_addr_data", {8'd0, imem_addr, imem_wdata}, {8'd0, exp_q[0]});
                exp_q.delete(0);
            end
        end
        if (load_done && !done_prev) begin
            chk("done_expected", {31'd0, exp_done}, 32'd1);
            chk("done_after_all_writes", exp_q.size(), 32'd0);
            if (exp_done_after_we) chk("done_one_cycle_after_we", {31'd0, we_prev}, 32'd1);
        end
        if (load_error && !err_prev) chk("error_expected", {31'd0, exp_err}, 32'd1);
        we_prev   <= imem_we;
        done_prev <= load_done;
        err_prev  <= load_error;
    end

    initial begin
        repeat (2) tick();
        do_reset();
        chk_reset_outputs("reset");

        // Two-word program.
        tmp = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_frame(with_csum(tmp), -1);
        chk("t1_done", {31'd0, load_done}, 32'd1);
        chk("t1_error", {31'd0, load_error}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_pending", exp_q.size(), 32'd0);
        chk("t1_nwrites", log_q.size(), 32'd2);
        if (log_q.size() >= 2) begin
            chk("t1_w0", {8'd0, log_q[0]}, 32'h00_00_1234);
            chk("t1_w1", {8'd0, log_q[1]}, 32'h00_01_ABCD);
        end

        // Empty program.
        do_reset();
        tmp = '{8'h00};
        send_frame(with_csum(tmp), -1);
        chk("t2_done", {31'd0, load_done}, 32'd1);
        chk("t2_error", {31'd0, load_error}, 32'd0);
        chk("t2_nwrites", log_q.size(), 32'd0);

        // Short low glitch on the idle line, then a frame still loads from L_COUNT.
        do_reset();
        build_model(tmp, -1);
        exp_done = 1'b0;
        UART_TXD_IN = 1'b0;
        repeat (5) tick();
        UART_TXD_IN = 1'b1;
        chk("t3_glitch_busy", {31'd0, busy}, 32'd1);
        repeat (20) tick();
        chk("t3_busy_back", {31'd0, busy}, 32'd0);
        chk("t3_done", {31'd0, load_done}, 32'd0);
        chk("t3_error", {31'd0, load_error}, 32'd0);
        send_frame(with_csum(tmp), -1);
        chk("t3_then_done", {31'd0, load_done}, 32'd1);
        chk("t3_nwrites", log_q.size(), 32'd0);

        // Framing error on the second byte; later bytes ignored.
        do_reset();
        tmp = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_frame(tmp, 1);
        chk("t4_error", {31'd0, load_error}, 32'd1);
        chk("t4_done", {31'd0, load_done}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_nwrites", log_q.size(), 32'd0);

        // Reset between the high and low bytes of word 1, then a fresh frame.
        do_reset();
        tmp = '{8'h02, 8'h12, 8'h34, 8'hAB};
        send_frame(tmp, -1);
        chk("t5_pending", exp_q.size(), 32'd0);
        chk("t5_wdata_held", {16'd0, imem_wdata}, 32'h0000_1234);
        chk("t5_busy_mid", {31'd0, busy}, 32'd1);
        RST = 1'b1;
        tick();
        chk_reset_outputs("t5_rst");
        RST = 1'b0;
        log_q.delete();
        tmp = '{8'h01, 8'h77, 8'h88};
        send_frame(with_csum(tmp), -1);
        chk("t5_done", {31'd0, load_done}, 32'd1);
        chk("t5_nwrites", log_q.size(), 32'd1);
        if (log_q.size() >= 1) chk("t5_w0", {8'd0, log_q[0]}, 32'h00_00_7788);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        tmp = '{8'h01, 8'h00, 8'h05, 8'hFA};
        send_frame(tmp, -1);
        chk("cs_ok_done", {31'd0, load_done}, 32'd1);
        chk("cs_ok_error", {31'd0, load_error}, 32'd0);
        if (log_q.size() >= 1) chk("cs_ok_w0", {8'd0, log_q[0]}, 32'h00_00_0005);
        do_reset();
        tmp = '{8'h01, 8'h00, 8'h05, 8'hFB};
        send_frame(tmp, -1);
        chk("cs_bad_error", {31'd0, load_error}, 32'd1);
        chk("cs_bad_done", {31'd0, load_done}, 32'd0);
        chk("cs_bad_nwrites", log_q.size(), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
